stream_mux: RTL and testbench
=============================

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, data width per channel in bits.
REQ-002 SHALL have parameter N_INPUTS, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL have parameter SEL_WIDTH, default 2, selector/grant width, equal to ceil(log2(N_INPUTS)).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  N_INPUTS*WORDSIZE  packed channel data; channel i occupies bits [i*WORDSIZE +: WORDSIZE].
REQ-007 SHALL have port in_valid  input  N_INPUTS  per-channel valid.
REQ-008 SHALL have port in_ready  output  N_INPUTS  per-channel ready; combinational.
REQ-009 SHALL have port sel  input  SEL_WIDTH  explicit channel select, used in mode 0.
REQ-010 SHALL have port mode  input  1  0 = explicit select, 1 = round-robin arbitration.
REQ-011 SHALL have port out_data  output  WORDSIZE  registered selected data.
REQ-012 SHALL have port out_valid  output  1  registered output valid.
REQ-013 SHALL have port out_ready  input  1  downstream ready.
REQ-014 SHALL have port out_grant  output  SEL_WIDTH  registered index of channel that sourced out_data.

Function
REQ-015 Transfer occurs on a channel when in_valid[i] and in_ready[i] are both 1 at a rising edge; on the output when out_valid and out_ready are both 1.
REQ-016 Output register can load when out_valid==0 or out_ready==1 (load_en); throughput 1 beat/cycle, latency 1 cycle from input transfer to out_valid.
REQ-017 At most one in_ready bit SHALL be 1 in any cycle; in_ready[g]=load_en for the chosen channel g, all others 0.
REQ-018 Mode 0: g=sel; in_ready[sel]=load_en regardless of in_valid[sel]; sel>=N_INPUTS -> all in_ready 0, no load.
REQ-019 Mode 1: g = first channel with in_valid set searching upward from rr_ptr with wrap at N_INPUTS-1 to 0; no valid channel -> all in_ready 0.
REQ-020 rr_ptr SHALL be an internal SEL_WIDTH register; on each mode-1 input transfer from channel g, rr_ptr <= (g+1) mod N_INPUTS; otherwise unchanged (also unchanged in mode 0).
REQ-021 On input transfer: out_data<=channel g data, out_grant<=g, out_valid<=1.
REQ-022 If load_en and no input transfer: out_valid<=0; out_data and out_grant hold.
REQ-023 Output stall (out_valid==1, out_ready==0): out_data, out_valid, out_grant SHALL hold; all in_ready 0.
REQ-024 Simultaneous output transfer and input transfer in one cycle: new beat loads, no bubble.
REQ-025 mode or sel change takes effect for the arbitration decision in the same cycle; beats already in the output register are unaffected.

Reset
REQ-026 rst_n low SHALL immediately force out_valid=0, out_data=0, out_grant=0, rr_ptr=0, independent of clk.
REQ-027 Reset asserted mid-stall SHALL discard the held beat; in_ready SHALL read 0 while rst_n is low.
REQ-028 First arbitration after reset release in mode 1 SHALL start search at channel 0.

Configuration
REQ-029 Macro STREAM_MUX_RR_EN defined: round-robin logic (REQ-019, REQ-020) compiled in; mode honoured.
REQ-030 Macro STREAM_MUX_RR_EN undefined: rr_ptr and round-robin logic absent; mode ignored, block behaves as mode 0 always.

Verification
REQ-031 Mode 0, sel=2, in_valid=4'b0100, ch2 data=64'hA5, out_ready=1 -> next cycle out_valid=1, out_data=64'hA5, out_grant=2; in_ready=4'b0100.
REQ-032 Mode 0, out_ready=0 after one load -> out_data/out_grant hold for 5 cycles, in_ready=0; raise out_ready -> drains, next beat loads same cycle.
REQ-033 Mode 1, in_valid=4'b1111 held, out_ready=1 -> out_grant sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 continuously.
REQ-034 Mode 1, in_valid=4'b1010, rr_ptr=0 -> grants 1,3,1,3; mode 1 with in_valid=0 -> out_valid falls to 0 after one cycle.
REQ-035 Assert rst_n low asynchronously mid-stall with out_valid=1 -> out_valid=0, out_data=0 before next clk edge; after release mode 1 grants channel 0 first if valid.
REQ-036 Build without STREAM_MUX_RR_EN, mode=1, sel=3, in_valid=4'b1111 -> only channel 3 granted every cycle.

Source files
------------

// File: rtl/stream_mux.sv
// N-channel stream multiplexer with a one-deep registered output stage.
// Define STREAM_MUX_RR_EN to compile in round-robin arbitration (mode=1); otherwise sel always chooses.
module stream_mux #(
  parameter int WORDSIZE  = 64,
  parameter int N_INPUTS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_INPUTS*WORDSIZE-1:0] in_data,
  input  logic [N_INPUTS-1:0]          in_valid,
  output logic [N_INPUTS-1:0]          in_ready,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         mode,
  output logic [WORDSIZE-1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_grant
);

  logic                 load_en;
  logic                 grant_ok;
  logic                 in_xfer;
  logic [SEL_WIDTH-1:0] grant;
  logic [WORDSIZE-1:0]  ch_data [N_INPUTS];

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WORDSIZE +: WORDSIZE];
  end

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign load_en = rst_n && (!out_valid || out_ready);

`ifdef STREAM_MUX_RR_EN
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [SEL_WIDTH-1:0]   rr_grant;
  logic                   rr_found;
  logic [2*N_INPUTS-1:0]  rr_dbl;
  int                     rr_sum;

  // Rotating a doubled copy by rr_ptr puts the search start at bit 0.
  always_comb begin
    rr_dbl   = {in_valid, in_valid} >> rr_ptr;
    rr_grant = '0;
    rr_found = 1'b0;
    rr_sum   = 0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (!rr_found && rr_dbl[k]) begin
        rr_found = 1'b1;
        rr_sum   = int'(rr_ptr) + k;
        if (rr_sum >= N_INPUTS) rr_sum = rr_sum - N_INPUTS;
        rr_grant = SEL_WIDTH'(rr_sum);
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = sel;
      grant_ok = (int'(sel) < N_INPUTS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (mode && in_xfer) begin
      rr_ptr <= (int'(grant) == N_INPUTS - 1) ? '0 : grant + 1'b1;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    grant    = sel;
    grant_ok = (int'(sel) < N_INPUTS);
  end
`endif

  always_comb begin
    in_ready = '0;
    if (grant_ok) in_ready[grant] = load_en;
  end

  assign in_xfer = grant_ok && load_en && in_valid[grant];

  // Output register: load on transfer, bubble when free with nothing to take, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
    end else if (load_en) begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant];
        out_grant <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Directed, table-driven bench for stream_mux; round-robin checks only when STREAM_MUX_RR_EN is defined.
module tb_stream_mux;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h0000_0000_0000_00A5;
  localparam logic [63:0] D3 = 64'hDEAD_BEEF_CAFE_F00D;

  logic         clk;
  logic         rst_n;
  logic [255:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         mode;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_grant;

  int checks = 0;
  int errors = 0;

  stream_mux #(.WORDSIZE(64), .N_INPUTS(4), .SEL_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_grant(out_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [63:0] exp_od;
    logic [1:0]  exp_og;
  } vec_t;

  vec_t vecs [7];
  logic [63:0] dexp [4];

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ov, input logic [63:0] od, input logic [1:0] og);
    checkValue({name, " out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    checkValue({name, " out_data"}, out_data, od);
    checkValue({name, " out_grant"}, {62'd0, out_grant}, {62'd0, og});
  endtask

  // Drives inputs just after a rising edge, checks comb in_ready, then advances one cycle.
  task automatic applyStimulus(input string name, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic r, input logic [3:0] exp_rdy);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
    #1;
    checkValue({name, " in_ready"}, {60'd0, in_ready}, {60'd0, exp_rdy});
    @(posedge clk);
    #1;
  endtask

  initial begin
    dexp[0] = D0; dexp[1] = D1; dexp[2] = D2; dexp[3] = D3;
    in_data   = {D3, D2, D1, D0};
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    out_ready = 1'b1;

    vecs[0] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
    vecs[1] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
    vecs[2] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, D0, 2'd0};
    vecs[3] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, D3, 2'd3};
    vecs[4] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, D3, 2'd3};
    vecs[5] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, D1, 2'd1};
    vecs[6] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0100, 1'b0, D1, 2'd1};

    // Reset state, with a valid request present that must not be acknowledged.
    #3;
    checkOutput("reset", 1'b0, 64'd0, 2'd0);
    checkValue("reset in_ready", {60'd0, in_ready}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].sel, vecs[i].valid,
                    vecs[i].ordy, vecs[i].exp_rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_og);
    end

    // Five-cycle stall holds the beat, then drain and reload happen in one cycle.
    applyStimulus("stall load", 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100);
    checkOutput("stall load", 1'b1, D2, 2'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("stall%0d", i), 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000);
      checkOutput($sformatf("stall%0d", i), 1'b1, D2, 2'd2);
    end
    applyStimulus("drain", 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001);
    checkOutput("drain", 1'b1, D0, 2'd0);

    // Asynchronous reset in the middle of a stall discards the held beat.
    applyStimulus("pre-reset stall", 1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000);
    checkOutput("pre-reset stall", 1'b1, D0, 2'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 1'b0, 64'd0, 2'd0);
    checkValue("async reset in_ready", {60'd0, in_ready}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef STREAM_MUX_RR_EN
    begin
      int seq_a [5] = '{0, 1, 2, 3, 0};
      int seq_b [4] = '{1, 3, 1, 3};
      for (int i = 0; i < 5; i++) begin
        applyStimulus($sformatf("rr all %0d", i), 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001 << seq_a[i]);
        checkOutput($sformatf("rr all %0d", i), 1'b1, dexp[seq_a[i]], 2'(seq_a[i]));
      end
      for (int i = 0; i < 4; i++) begin
        applyStimulus($sformatf("rr odd %0d", i), 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0001 << seq_b[i]);
        checkOutput($sformatf("rr odd %0d", i), 1'b1, dexp[seq_b[i]], 2'(seq_b[i]));
      end
      applyStimulus("rr idle", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
      checkOutput("rr idle", 1'b0, D3, 2'd3);
      applyStimulus("mode0 switch", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
      checkOutput("mode0 switch", 1'b1, D2, 2'd2);
      applyStimulus("rr resume", 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0001);
      checkOutput("rr resume", 1'b1, D0, 2'd0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("mode ignored %0d", i), 1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000);
      checkOutput($sformatf("mode ignored %0d", i), 1'b1, D3, 2'd3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
